// File: rtl/control_m_axi_read_master_ctrl.sv
// rtl/control_m_axi_read_master_ctrl.sv - AXI4 read-master burst controller with AXI-Stream output
module control_m_axi_read_master_ctrl #(
    parameter int C_M_AXI_ADDR_WIDTH = 64,
    parameter int C_M_AXI_DATA_WIDTH = 512,
    parameter int C_XFER_SIZE_WIDTH  = 32,
    parameter int C_BURST_LEN        = 64,
    parameter int C_MAX_OUTSTANDING  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ctrl_start,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_offset,
    input  logic [C_XFER_SIZE_WIDTH-1:0]  ctrl_length,
    output logic                          ctrl_done,
    output logic                          m_axi_arvalid,
    input  logic                          m_axi_arready,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]                    m_axi_arlen,
    input  logic                          m_axi_rvalid,
    output logic                          m_axi_rready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_rdata,
    input  logic                          m_axi_rlast,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [C_M_AXI_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                          m_axis_tlast
);

    localparam int AW        = C_M_AXI_ADDR_WIDTH;
    localparam int XW        = C_XFER_SIZE_WIDTH;
    localparam int BURST_LOG = $clog2(C_BURST_LEN);
    localparam int OUT_W     = $clog2(C_MAX_OUTSTANDING + 1);
    localparam logic [AW-1:0]    BURST_BYTES = AW'(C_BURST_LEN * (C_M_AXI_DATA_WIDTH / 8));
    localparam logic [XW-1:0]    ONE_X       = XW'(1);
    localparam logic [XW-1:0]    BURST_MASK  = XW'(C_BURST_LEN - 1);
    localparam logic [OUT_W-1:0] ONE_O       = OUT_W'(1);
    localparam logic [OUT_W-1:0] MAX_O       = OUT_W'(C_MAX_OUTSTANDING);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t           state_q;
    logic [XW-1:0]    len_q;
    logic [XW-1:0]    beat_cnt_q;
    logic [XW-1:0]    bursts_left_q;
    logic [AW-1:0]    next_addr_q;
    logic [OUT_W-1:0] outst_q;
    logic [OUT_W-1:0] outst_d;
    logic             arvalid_q;
    logic [AW-1:0]    araddr_q;
    logic [7:0]       arlen_q;
    logic             done_q;

    logic             busy;
    logic             ar_hs;
    logic             r_hs;
    logic             r_burst_end;
    logic             final_beat;
    logic             raise_ar;
    logic [XW-1:0]    start_bursts;
    logic [7:0]       last_arlen;

    assign busy        = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign ar_hs       = arvalid_q & m_axi_arready;
    assign r_hs        = m_axi_rvalid & m_axi_rready;
    assign r_burst_end = r_hs & m_axi_rlast;
    assign final_beat  = r_hs & m_axis_tlast;

    assign m_axi_rready  = m_axis_tready & busy;
    assign m_axis_tvalid = m_axi_rvalid & busy;
    assign m_axis_tdata  = m_axi_rdata;
    // Transfer-level last is derived from the beat count, not from per-burst rlast.
    assign m_axis_tlast  = busy && (beat_cnt_q == len_q - ONE_X);

    assign m_axi_arvalid = arvalid_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arlen   = arlen_q;
    assign ctrl_done     = done_q;

    assign start_bursts = (ctrl_length >> BURST_LOG) + XW'(|ctrl_length[BURST_LOG-1:0]);
    assign last_arlen   = 8'((len_q - ONE_X) & BURST_MASK);

    always_comb begin
        outst_d = outst_q;
        if (ar_hs && !r_burst_end) begin
            outst_d = outst_q + ONE_O;
        end else if (!ar_hs && r_burst_end && (outst_q != '0)) begin
            outst_d = outst_q - ONE_O;
        end
    end

    // Looking at the post-edge count lets AR issue back-to-back without overshooting the cap.
    assign raise_ar = (state_q == S_ISSUE) && (bursts_left_q != '0) &&
                      (!arvalid_q || ar_hs) && (outst_d < MAX_O);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            len_q         <= '0;
            beat_cnt_q    <= '0;
            bursts_left_q <= '0;
            next_addr_q   <= '0;
            outst_q       <= '0;
            arvalid_q     <= 1'b0;
            araddr_q      <= '0;
            arlen_q       <= '0;
            done_q        <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            outst_q <= outst_d;
            if (r_hs) begin
                beat_cnt_q <= beat_cnt_q + ONE_X;
            end
            if (ar_hs) begin
                arvalid_q <= 1'b0;
            end
            if (raise_ar) begin
                arvalid_q     <= 1'b1;
                araddr_q      <= next_addr_q;
                arlen_q       <= (bursts_left_q == ONE_X) ? last_arlen : 8'(C_BURST_LEN - 1);
                next_addr_q   <= next_addr_q + BURST_BYTES;
                bursts_left_q <= bursts_left_q - ONE_X;
            end
            case (state_q)
                S_IDLE: begin
                    if (ctrl_start) begin
                        len_q         <= ctrl_length;
                        next_addr_q   <= ctrl_offset;
                        bursts_left_q <= start_bursts;
                        beat_cnt_q    <= '0;
                        if (ctrl_length == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (ar_hs && (bursts_left_q == '0)) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (final_beat) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_m_axi_read_master_ctrl.sv
// tb/tb_control_m_axi_read_master_ctrl.sv - self-checking bench for the AXI read-master controller
module tb_control_m_axi_read_master_ctrl;

    localparam int AW = 64;
    localparam int DW = 512;
    localparam int XW = 32;
    localparam int BL = 64;
    localparam int MO = 16;
    localparam int BEAT_B  = DW / 8;
    localparam int BURST_B = BL * BEAT_B;

    logic          clk = 1'b0;
    logic          rst;
    logic          ctrl_start;
    logic [AW-1:0] ctrl_offset;
    logic [XW-1:0] ctrl_length;
    logic          ctrl_done;
    logic          arvalid, arready;
    logic [AW-1:0] araddr;
    logic [7:0]    arlen;
    logic          rvalid, rready, rlast;
    logic [DW-1:0] rdata;
    logic          tvalid, tready, tlast;
    logic [DW-1:0] tdata;

    always #5 clk = ~clk;

    control_m_axi_read_master_ctrl #(
        .C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_DATA_WIDTH(DW), .C_XFER_SIZE_WIDTH(XW),
        .C_BURST_LEN(BL), .C_MAX_OUTSTANDING(MO)
    ) dut (
        .clk(clk), .rst(rst),
        .ctrl_start(ctrl_start), .ctrl_offset(ctrl_offset), .ctrl_length(ctrl_length),
        .ctrl_done(ctrl_done),
        .m_axi_arvalid(arvalid), .m_axi_arready(arready), .m_axi_araddr(araddr), .m_axi_arlen(arlen),
        .m_axi_rvalid(rvalid), .m_axi_rready(rready), .m_axi_rdata(rdata), .m_axi_rlast(rlast),
        .m_axis_tvalid(tvalid), .m_axis_tready(tready), .m_axis_tdata(tdata), .m_axis_tlast(tlast)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Transfer model: phase, latched request, issued bursts and delivered beats.
    typedef enum {M_IDLE, M_BUSY, M_DONE} mphase_t;
    mphase_t       mph = M_IDLE;
    logic [AW-1:0] m_off;
    int            m_len, m_nb, ar_k, beat_i, outst;
    int            cyc = 0, done_cnt = 0, done_cyc = -1, last_beat_cyc = -1, start_cyc = -1;
    logic [AW-1:0] ar_log_addr[$];
    int            ar_log_len[$];

    // Memory-side slave: queue of accepted bursts, beats served in order.
    logic [AW-1:0] sq_addr[$];
    int            sq_len[$];
    int            s_beat = 0;
    int            rv_budget = -1;
    bit            rnd_ar = 0, rnd_t = 0, rnd_r = 0;
    logic          prev_stall = 1'b0;
    logic [AW-1:0] prev_araddr;
    logic [7:0]    prev_arlen;

    logic          nx_arready, nx_rvalid, nx_rlast, nx_tready;
    logic [DW-1:0] nx_rdata;
    logic [AW-1:0] e_addr;
    bit            ar_hs, r_hs, s_hs, fin;

    initial begin
        arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = '0; tready = 1'b1;
        forever begin
            @(negedge clk);
            cyc++;
            ar_hs = arvalid && arready;
            r_hs  = rvalid && rready;
            s_hs  = tvalid && tready;
            fin   = 0;
            if (rst) begin
                mph = M_IDLE;
                sq_addr.delete(); sq_len.delete();
                s_beat = 0; outst = 0; prev_stall = 1'b0;
                nx_rvalid = 1'b0; nx_rlast = 1'b0; nx_rdata = '0;
            end else begin
                chk("ctrl_done", ctrl_done, mph == M_DONE);
                if (ctrl_done) begin done_cnt++; done_cyc = cyc; end
                if (mph == M_BUSY) begin
                    chk("tvalid_pass", tvalid, rvalid);
                    chk("rready_pass", rready, tready);
                    if (tvalid) chk("tdata_pass", tdata, rdata);
                    if (tvalid) chk("tlast", tlast, beat_i == m_len - 1);
                end else begin
                    chk("idle_rready", rready, 1'b0);
                    chk("idle_tvalid", tvalid, 1'b0);
                    chk("idle_arvalid", arvalid, 1'b0);
                end
                if (prev_stall) begin
                    chk("ar_hold_valid", arvalid, 1'b1);
                    chk("ar_hold_addr", araddr, prev_araddr);
                    chk("ar_hold_len", arlen, prev_arlen);
                end
                prev_stall = arvalid && !arready;
                prev_araddr = araddr;
                prev_arlen = arlen;
                if (ar_hs) begin
                    if (mph != M_BUSY || ar_k >= m_nb) begin
                        fail_now("unexpected_ar");
                    end else begin
                        e_addr = m_off + AW'(ar_k) * AW'(BURST_B);
                        chk("araddr", araddr, e_addr);
                        chk("arlen", arlen, (ar_k == m_nb - 1) ? (m_len - 1) % BL : BL - 1);
                    end
                    ar_k++;
                    ar_log_addr.push_back(araddr);
                    ar_log_len.push_back(int'(arlen));
                    sq_addr.push_back(araddr);
                    sq_len.push_back(int'(arlen));
                    outst++;
                end
                if (s_hs && mph == M_BUSY) begin
                    e_addr = m_off + AW'(beat_i) * AW'(BEAT_B);
                    chk("tdata_order", tdata, {8{e_addr}});
                    if (beat_i == m_len - 1) begin fin = 1; last_beat_cyc = cyc; end
                    beat_i++;
                end
                if (r_hs && rlast) outst--;
                chk("outstanding_cap", outst <= MO, 1'b1);
                case (mph)
                    M_IDLE: if (ctrl_start) begin
                        m_off = ctrl_offset; m_len = int'(ctrl_length);
                        m_nb = (m_len + BL - 1) / BL; ar_k = 0; beat_i = 0; start_cyc = cyc;
                        mph = (m_len == 0) ? M_DONE : M_BUSY;
                    end
                    M_BUSY: if (fin) mph = M_DONE;
                    default: mph = M_IDLE;
                endcase
                if (r_hs) begin
                    if (rlast) begin
                        void'(sq_addr.pop_front()); void'(sq_len.pop_front()); s_beat = 0;
                    end else begin
                        s_beat++;
                    end
                    if (rv_budget > 0) rv_budget--;
                end
                if (rvalid && !r_hs) begin
                    nx_rvalid = 1'b1; nx_rlast = rlast; nx_rdata = rdata;
                end else if (sq_addr.size() > 0 && rv_budget != 0 &&
                             (!rnd_r || $urandom_range(0, 3) != 0)) begin
                    e_addr = sq_addr[0] + AW'(s_beat) * AW'(BEAT_B);
                    nx_rvalid = 1'b1; nx_rlast = (s_beat == sq_len[0]); nx_rdata = {8{e_addr}};
                end else begin
                    nx_rvalid = 1'b0; nx_rlast = 1'b0; nx_rdata = '0;
                end
            end
            nx_arready = rnd_ar ? 1'($urandom_range(0, 1)) : 1'b1;
            nx_tready  = rnd_t ? ($urandom_range(0, 2) != 0) : 1'b1;
            @(posedge clk);
            #1;
            arready = nx_arready; rvalid = nx_rvalid; rlast = nx_rlast; rdata = nx_rdata; tready = nx_tready;
        end
    end

    task automatic start_xfer(input logic [AW-1:0] off, input int len);
        @(posedge clk); #1;
        ctrl_offset = off; ctrl_length = XW'(len); ctrl_start = 1'b1;
        @(posedge clk); #1;
        ctrl_start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int d0 = done_cnt;
        int n = 0;
        while (done_cnt == d0 && n < budget) begin @(posedge clk); n++; end
        if (done_cnt == d0) fail_now({name, "_timeout"});
    endtask

    initial begin
        int d0;
        int n;
        rst = 1'b1; ctrl_start = 1'b0; ctrl_offset = '0; ctrl_length = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_arvalid", arvalid, 1'b0);
        chk("reset_araddr", araddr, '0);
        chk("reset_arlen", arlen, '0);
        chk("reset_done", ctrl_done, 1'b0);
        chk("reset_rready", rready, 1'b0);
        @(posedge clk); #1; rst = 1'b0;

        // One full burst.
        ar_log_addr.delete(); ar_log_len.delete();
        start_xfer(64'h1000, 64);
        wait_done("t1", 500);
        chk("t1_ar_count", ar_log_addr.size(), 1);
        chk("t1_araddr", ar_log_addr[0], 64'h1000);
        chk("t1_arlen", ar_log_len[0], 63);
        chk("t1_done_latency", done_cyc, last_beat_cyc + 1);

        // Three bursts, partial last, with an ignored start mid-transfer.
        ar_log_addr.delete(); ar_log_len.delete();
        d0 = done_cnt;
        start_xfer(64'h20000, 130);
        repeat (5) @(posedge clk);
        #1; ctrl_offset = 64'hDEAD_0000; ctrl_length = 5; ctrl_start = 1'b1;
        @(posedge clk); #1; ctrl_start = 1'b0;
        wait_done("t2", 1000);
        repeat (4) @(posedge clk);
        chk("t2_done_pulses", done_cnt - d0, 1);
        chk("t2_ar_count", ar_log_addr.size(), 3);
        chk("t2_addr0", ar_log_addr[0], 64'h20000);
        chk("t2_addr1", ar_log_addr[1], 64'h21000);
        chk("t2_addr2", ar_log_addr[2], 64'h22000);
        chk("t2_len0", ar_log_len[0], 63);
        chk("t2_len1", ar_log_len[1], 63);
        chk("t2_len2", ar_log_len[2], 1);

        // Zero length: done only, no AR.
        ar_log_addr.delete(); ar_log_len.delete();
        start_xfer(64'h3000, 0);
        wait_done("t4", 20);
        chk("t4_ar_count", ar_log_addr.size(), 0);
        chk("t4_done_latency", done_cyc, start_cyc + 1);

        // Outstanding cap with R held off, then one burst released.
        ar_log_addr.delete(); ar_log_len.delete();
        rv_budget = 0;
        start_xfer(64'h0, 64 * 20);
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("t3_capped_ars", ar_log_addr.size(), 16);
        chk("t3_arvalid_low", arvalid, 1'b0);
        @(posedge clk); #1; rv_budget = 64;
        repeat (100) @(posedge clk);
        @(negedge clk);
        chk("t3_one_more_ar", ar_log_addr.size(), 17);
        @(posedge clk); #1; rv_budget = -1;
        wait_done("t3", 5000);
        chk("t3_total_ars", ar_log_addr.size(), 20);

        // Random stalls, address wrap and burst-size boundaries.
        rnd_ar = 1; rnd_t = 1; rnd_r = 1;
        ar_log_addr.delete(); ar_log_len.delete();
        start_xfer(64'hFFFF_FFFF_FFFF_F000, 130);
        wait_done("t5_wrap", 3000);
        chk("t5_wrap_addr1", ar_log_addr[1], 64'h0);
        start_xfer(64'h4000_0000, 200);
        wait_done("t5_200", 4000);
        start_xfer(64'h8000, 1);
        wait_done("t5_1", 500);
        start_xfer(64'h9000, 65);
        wait_done("t5_65", 2000);
        start_xfer(64'hA000, 64 * 18 + 3);
        wait_done("t5_long", 20000);
        rnd_ar = 0; rnd_t = 0; rnd_r = 0;

        // Reset in DRAIN, then a clean transfer.
        start_xfer(64'h8000, 130);
        n = 0;
        while (!(mph == M_BUSY && ar_k == 3 && beat_i >= 70) && n < 1000) begin @(posedge clk); n++; end
        if (n >= 1000) fail_now("t6_reach_drain_timeout");
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        d0 = done_cnt;
        @(negedge clk);
        chk("t6_arvalid", arvalid, 1'b0);
        chk("t6_rready", rready, 1'b0);
        chk("t6_done", ctrl_done, 1'b0);
        repeat (5) @(posedge clk);
        chk("t6_no_done", done_cnt - d0, 0);
        ar_log_addr.delete(); ar_log_len.delete();
        start_xfer(64'h1000, 64);
        wait_done("t6_fresh", 500);
        chk("t6_fresh_ars", ar_log_addr.size(), 1);
        chk("t6_fresh_addr", ar_log_addr[0], 64'h1000);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
